// File: rtl/road_rom_arbiter.sv
// Two-requester arbiter (solver / renderer) for the single-port road ROM.
// Define ROAD_ARB_FAIR_EN to enable the renderer starvation guard; otherwise strict solver priority.
module road_rom_arbiter #(
   parameter int AW      = 10,
   parameter int DW      = 64,
   parameter int MAXWAIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_req,
   input  logic [AW-1:0] s_addr,
   output logic          s_gnt,
   output logic          s_rvalid,
   output logic [DW-1:0] s_rdata,
   input  logic          r_req,
   input  logic [AW-1:0] r_addr,
   output logic          r_gnt,
   output logic          r_rvalid,
   output logic [DW-1:0] r_rdata,
   output logic [AW-1:0] rom_a,
   input  logic [DW-1:0] rom_d,
   output logic          busy,
   output logic [15:0]   r_stall
);

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

   state_t r_state;
   logic   r_owner;   // 0: solver, 1: renderer
   logic   w_r_win;

`ifdef ROAD_ARB_FAIR_EN
   logic [3:0] r_wcnt;
   logic       w_force_r;

   assign w_force_r = (r_wcnt == 4'(MAXWAIT));
   assign w_r_win   = r_req & (~s_req | w_force_r);

   // Counts consecutive contested solver wins; any gap in r_req forgives the wait.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wcnt <= 4'd0;
      end else if (!r_req) begin
         r_wcnt <= 4'd0;
      end else if (r_state == IDLE) begin
         if (w_r_win)
            r_wcnt <= 4'd0;
         else if (s_req)
            r_wcnt <= r_wcnt + 4'd1;
      end
   end
`else
   logic w_unused_maxwait;

   assign w_r_win          = r_req & ~s_req;
   assign w_unused_maxwait = (MAXWAIT > 0);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_owner  <= 1'b0;
         rom_a    <= '0;
         s_gnt    <= 1'b0;
         r_gnt    <= 1'b0;
         s_rvalid <= 1'b0;
         r_rvalid <= 1'b0;
         busy     <= 1'b0;
         s_rdata  <= '0;
         r_rdata  <= '0;
         r_stall  <= 16'd0;
      end else begin
         s_gnt    <= 1'b0;
         r_gnt    <= 1'b0;
         s_rvalid <= 1'b0;
         r_rvalid <= 1'b0;

         if (r_req && !r_gnt && (r_stall != 16'hFFFF))
            r_stall <= r_stall + 16'd1;

         case (r_state)
            IDLE: begin
               if (s_req || r_req) begin
                  r_state <= READ;
                  busy    <= 1'b1;
                  r_owner <= w_r_win;
                  if (w_r_win) begin
                     rom_a <= r_addr;
                     r_gnt <= 1'b1;
                  end else begin
                     rom_a <= s_addr;
                     s_gnt <= 1'b1;
                  end
               end
            end
            READ: begin
               // rom_d is a combinational read of rom_a, settled by now.
               r_state <= IDLE;
               busy    <= 1'b0;
               if (r_owner) begin
                  r_rdata  <= rom_d;
                  r_rvalid <= 1'b1;
               end else begin
                  s_rdata  <= rom_d;
                  s_rvalid <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_road_rom_arbiter.sv
// Directed bench for road_rom_arbiter: vector table plus hand-written contested/reset sequences.
module tb_road_rom_arbiter;
   localparam int AW      = 10;
   localparam int DW      = 64;
   localparam int MAXWAIT = 4;

   logic          clk;
   logic          rst;
   logic          s_req, r_req;
   logic [AW-1:0] s_addr, r_addr;
   logic          s_gnt, s_rvalid, r_gnt, r_rvalid, busy;
   logic [DW-1:0] s_rdata, r_rdata, rom_d;
   logic [AW-1:0] rom_a;
   logic [15:0]   r_stall;

   int n_pass  = 0;
   int n_total = 0;

   road_rom_arbiter #(.AW(AW), .DW(DW), .MAXWAIT(MAXWAIT)) dut (
      .clk(clk), .rst(rst),
      .s_req(s_req), .s_addr(s_addr), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rvalid(r_rvalid), .r_rdata(r_rdata),
      .rom_a(rom_a), .rom_d(rom_d), .busy(busy), .r_stall(r_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM model: known word at 20, address-tagged pattern elsewhere.
   function automatic logic [63:0] rom_fn(input logic [9:0] a);
      if (a == 10'd20) return 64'h0064_0032_8168_005A;
      return 64'hC0DE_0000_0000_0000 | {22'd0, a, 16'd0, 6'd0, a};
   endfunction

   always_comb rom_d = rom_fn(rom_a);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic do_reset();
      s_req = 1'b0; r_req = 1'b0; s_addr = '0; r_addr = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        s_req;
      logic [9:0]  s_addr;
      logic        r_req;
      logic [9:0]  r_addr;
      logic [4:0]  ctl;    // {s_gnt, r_gnt, s_rvalid, r_rvalid, busy}
      logic [9:0]  roma;
      logic [63:0] srd;
      logic [63:0] rrd;
      logic [15:0] stall;
   } vec_t;

   vec_t vecs[8];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic es, er;
      logic [63:0] r20, r5, r6;
      r20 = rom_fn(10'd20);
      r5  = rom_fn(10'd5);
      r6  = rom_fn(10'd6);

      vecs[0] = '{1'b1, 10'd20, 1'b0, 10'd0, 5'b10001, 10'd20, 64'd0, 64'd0, 16'd0};
      vecs[1] = '{1'b0, 10'd0,  1'b0, 10'd0, 5'b00100, 10'd20, r20,   64'd0, 16'd0};
      vecs[2] = '{1'b0, 10'd0,  1'b0, 10'd0, 5'b00000, 10'd20, r20,   64'd0, 16'd0};
      vecs[3] = '{1'b0, 10'd0,  1'b1, 10'd5, 5'b01001, 10'd5,  r20,   64'd0, 16'd1};
      vecs[4] = '{1'b0, 10'd0,  1'b1, 10'd6, 5'b00010, 10'd5,  r20,   r5,    16'd1};
      vecs[5] = '{1'b0, 10'd0,  1'b1, 10'd6, 5'b01001, 10'd6,  r20,   r5,    16'd2};
      vecs[6] = '{1'b0, 10'd0,  1'b0, 10'd0, 5'b00010, 10'd6,  r20,   r6,    16'd2};
      vecs[7] = '{1'b0, 10'd0,  1'b0, 10'd0, 5'b00000, 10'd6,  r20,   r6,    16'd2};

      // Reset state
      s_req = 1'b0; r_req = 1'b0; s_addr = '0; r_addr = '0; rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_ctl", {s_gnt, r_gnt, s_rvalid, r_rvalid, busy}, 5'b00000);
      chk("reset_rom_a", rom_a, 0);
      chk("reset_s_rdata", s_rdata, 0);
      chk("reset_r_rdata", r_rdata, 0);
      chk("reset_r_stall", r_stall, 0);
      rst = 1'b0;

      // Solver-only read, then renderer back-to-back with r_req held
      for (int i = 0; i < 8; i++) begin
         s_req = vecs[i].s_req; s_addr = vecs[i].s_addr;
         r_req = vecs[i].r_req; r_addr = vecs[i].r_addr;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), {s_gnt, r_gnt, s_rvalid, r_rvalid, busy}, vecs[i].ctl);
         chk($sformatf("vec%0d_rom_a", i), rom_a, vecs[i].roma);
         chk($sformatf("vec%0d_s_rdata", i), s_rdata, vecs[i].srd);
         chk($sformatf("vec%0d_r_rdata", i), r_rdata, vecs[i].rrd);
         chk($sformatf("vec%0d_r_stall", i), r_stall, vecs[i].stall);
      end

      // Both requesters held for 40 cycles
      do_reset();
      s_req = 1'b1; s_addr = 10'd100; r_req = 1'b1; r_addr = 10'd200;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         es = (k % 2 == 0);
         er = 1'b0;
`ifdef ROAD_ARB_FAIR_EN
         if ((k % 2 == 0) && ((k / 2) % 5 == 4)) begin
            es = 1'b0;
            er = 1'b1;
         end
         if (k == 8) chk("stall_before_first_rgnt", r_stall, 9);
`endif
         chk($sformatf("contest_gnt%0d", k), {s_gnt, r_gnt}, {es, er});
      end
      chk("contest_s_rdata", s_rdata, rom_fn(10'd100));
`ifdef ROAD_ARB_FAIR_EN
      chk("contest_r_rdata", r_rdata, rom_fn(10'd200));
`else
      chk("contest_r_rdata", r_rdata, 0);
      chk("contest_r_stall40", r_stall, 40);
`endif
      s_req = 1'b0; r_req = 1'b0;
      @(negedge clk);

      // Reset during the READ cycle of a solver read
      do_reset();
      s_req = 1'b1; s_addr = 10'd30;
      @(negedge clk);
      chk("rstread_gnt", {s_gnt, busy}, 2'b11);
      s_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rstread_no_rvalid", {s_rvalid, r_rvalid, busy}, 3'b000);
      chk("rstread_s_rdata", s_rdata, 0);
      rst = 1'b0;
      s_req = 1'b1; s_addr = 10'd31;
      @(negedge clk);
      chk("rstread_regnt", {s_gnt, busy}, 2'b11);
      chk("rstread_rom_a", rom_a, 31);
      s_req = 1'b0;
      @(negedge clk);
      chk("rstread_rvalid", s_rvalid, 1);
      chk("rstread_data", s_rdata, rom_fn(10'd31));

      // r_req dropped for one cycle after three contested solver wins
      do_reset();
      s_req = 1'b1; s_addr = 10'd40; r_req = 1'b1; r_addr = 10'd41;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         es = (k % 2 == 0);
         er = 1'b0;
`ifdef ROAD_ARB_FAIR_EN
         if (k == 14) begin
            es = 1'b0;
            er = 1'b1;
         end
`endif
         chk($sformatf("wdrop_gnt%0d", k), {s_gnt, r_gnt}, {es, er});
         if (k == 4) r_req = 1'b0;
         if (k == 5) r_req = 1'b1;
      end
      s_req = 1'b0; r_req = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
